// File: rtl/clock_pkg.sv
// clock_pkg: shared state encodings, 1 MHz timing defaults and the SET-key
// state sequencing helper for the clock time-set controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  // Default cycle counts for a 1 MHz system clock
  localparam int unsigned DEF_HOLD_CYC    = 500000;    // 0.5 s before auto-repeat
  localparam int unsigned DEF_REPEAT_CYC  = 100000;    // 0.1 s between repeats
  localparam int unsigned DEF_TIMEOUT_CYC = 10000000;  // 10 s inactivity timeout
  localparam int unsigned DEF_BLINK_CYC   = 250000;    // 250 ms blink half-period

  // State reached on a SET press: RUN -> SET_HOUR -> SET_MIN -> RUN
  function automatic state_t next_set_state(input state_t cur);
    state_t nxt;
    case (cur)
      ST_RUN:      nxt = ST_SET_HOUR;
      ST_SET_HOUR: nxt = ST_SET_MIN;
      default:     nxt = ST_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// key_repeat: press detector on a debounced key level plus hold/auto-repeat
// pulse generator. 'press' is the raw rising edge of the registered level;
// 'fire' is an increment request (first press or repeat) unless cancelled.
// A cancel also disarms any pending repeat, so the key must be released and
// pressed again before it can fire.
module key_repeat
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic cancel,
  output logic press,
  output logic fire
);

  localparam int unsigned CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic             key_reg;
  logic             key_dly_reg;
  logic [1:0]       arm_reg;
  logic             active_reg;
  logic             rep_phase_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rep_due;

  // Register the key level and its delayed copy; arm_reg masks the first two
  // cycles after reset so a key held through reset release is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg     <= 1'b0;
      key_dly_reg <= 1'b0;
      arm_reg     <= 2'b00;
    end else begin
      key_reg     <= key;
      key_dly_reg <= key_reg;
      arm_reg     <= {arm_reg[0], 1'b1};
    end
  end

  // Press edge and repeat-due decode; cancel suppresses any increment request
  always_comb begin
    press   = key_reg & ~key_dly_reg & arm_reg[1];
    rep_due = active_reg & key_reg &
              (rep_phase_reg ? (cnt_reg == CNT_W'(REPEAT_CYC))
                             : (cnt_reg == CNT_W'(HOLD_CYC)));
    fire    = ~cancel & (press | rep_due);
  end

  // Hold/repeat sequencer: count from the first pulse, fire after HOLD_CYC,
  // then every REPEAT_CYC while the key stays high; release or cancel disarms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg    <= 1'b0;
      rep_phase_reg <= 1'b0;
      cnt_reg       <= '0;
    end else if (cancel || !key_reg) begin
      active_reg    <= 1'b0;
      rep_phase_reg <= 1'b0;
      cnt_reg       <= '0;
    end else if (press) begin
      active_reg    <= 1'b1;
      rep_phase_reg <= 1'b0;
      cnt_reg       <= CNT_W'(1);
    end else if (rep_due) begin
      rep_phase_reg <= 1'b1;
      cnt_reg       <= CNT_W'(1);
    end else if (active_reg && (cnt_reg != CNT_W'(CNT_MAX))) begin
      cnt_reg       <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: front-panel time-set sequencer. SET steps RUN -> SET_HOUR ->
// SET_MIN -> RUN, UP (with auto-repeat) increments the field being set, an
// inactivity timeout returns to RUN, and the field being set blinks.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC  = DEF_REPEAT_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned BLINK_CYC   = DEF_BLINK_CYC
) (
  input  logic       CLK_1M,
  input  logic       clr,
  input  logic       key_set,
  input  logic       key_up,
  output logic       enable,
  output logic       hadd,
  output logic       madd,
  output logic [3:0] blank,
  output logic [1:0] set_state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BLK_W = $clog2(BLINK_CYC + 1);

  state_t             state_reg;
  state_t             state_next;
  logic               set_reg;
  logic               set_dly_reg;
  logic [1:0]         set_arm_reg;
  logic               set_press;
  logic               up_press;
  logic               up_fire;
  logic               rep_cancel;
  logic               in_set;
  logic               state_change;
  logic               tmo_hit;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [BLK_W-1:0]   blink_cnt_reg;
  logic               phase_reg;
  logic               hadd_reg;
  logic               madd_reg;

  // SET key edge detect; masked for two cycles after reset like the UP key
  always_ff @(posedge CLK_1M or posedge clr) begin
    if (clr) begin
      set_reg     <= 1'b0;
      set_dly_reg <= 1'b0;
      set_arm_reg <= 2'b00;
    end else begin
      set_reg     <= key_set;
      set_dly_reg <= set_reg;
      set_arm_reg <= {set_arm_reg[0], 1'b1};
    end
  end

  // Press, timeout and repeat-cancel decode; any state change cancels repeat
  always_comb begin
    set_press  = set_reg & ~set_dly_reg & set_arm_reg[1];
    in_set     = (state_reg != ST_RUN);
    tmo_hit    = in_set & ~set_press & ~up_press &
                 (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
    rep_cancel = ~in_set | set_press | tmo_hit;
  end

  key_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_up_key (
    .clk    (CLK_1M),
    .rst    (clr),
    .key    (key_up),
    .cancel (rep_cancel),
    .press  (up_press),
    .fire   (up_fire)
  );

  // State register
  always_ff @(posedge CLK_1M or posedge clr) begin
    if (clr) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a SET press takes priority over the timeout
  always_comb begin
    state_next = state_reg;
    if (set_press) begin
      state_next = next_set_state(state_reg);
    end else if (tmo_hit) begin
      state_next = ST_RUN;
    end
    state_change = (state_next != state_reg);
  end

  // Output decode from the registered state and blink phase
  always_comb begin
    enable    = (state_reg == ST_RUN);
    set_state = state_reg;
    blank     = 4'b0000;
    case (state_reg)
      ST_SET_HOUR: blank = {phase_reg, phase_reg, 2'b00};
      ST_SET_MIN:  blank = {2'b00, phase_reg, phase_reg};
      default:     blank = 4'b0000;
    endcase
  end

  // Route increment requests to the hour or minute pulse, one cycle wide
  always_ff @(posedge CLK_1M or posedge clr) begin
    if (clr) begin
      hadd_reg <= 1'b0;
      madd_reg <= 1'b0;
    end else begin
      hadd_reg <= up_fire & (state_reg == ST_SET_HOUR);
      madd_reg <= up_fire & (state_reg == ST_SET_MIN);
    end
  end

  assign hadd = hadd_reg;
  assign madd = madd_reg;

  // Inactivity counter: cleared on any press, on state entry and in RUN
  always_ff @(posedge CLK_1M or posedge clr) begin
    if (clr) begin
      tmo_cnt_reg <= '0;
    end else if (!in_set || state_change || set_press || up_press) begin
      tmo_cnt_reg <= '0;
    end else if (tmo_cnt_reg != TMO_W'(TIMEOUT_CYC - 1)) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end
  end

  // Blink phase: restarts visible on state entry and on each increment so the
  // digit being changed stays lit, then toggles every BLINK_CYC cycles
  always_ff @(posedge CLK_1M or posedge clr) begin
    if (clr) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (!in_set || state_change || up_fire) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLK_W'(BLINK_CYC - 1)) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scenarios plus randomized key traffic, checked
// every cycle against a timestamp-based model of the time-set controller.
module tb_clock_set_ctrl;

  localparam int HOLD = 50;
  localparam int REP  = 10;
  localparam int TMO  = 1000;
  localparam int BLK  = 25;

  logic       CLK_1M = 1'b0;
  logic       clr;
  logic       key_set;
  logic       key_up;
  logic       enable;
  logic       hadd;
  logic       madd;
  logic [3:0] blank;
  logic [1:0] set_state;

  clock_set_ctrl #(
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP),
    .TIMEOUT_CYC (TMO),
    .BLINK_CYC   (BLK)
  ) dut (
    .CLK_1M    (CLK_1M),
    .clr       (clr),
    .key_set   (key_set),
    .key_up    (key_up),
    .enable    (enable),
    .hadd      (hadd),
    .madd      (madd),
    .blank     (blank),
    .set_state (set_state)
  );

  always #5 CLK_1M = ~CLK_1M;

  int total = 0;
  int bad   = 0;
  int tb_cyc = 0;
  int cnt_h = 0;
  int cnt_m = 0;
  int last_chg = 0;
  logic [1:0] prev_ss = 2'd0;
  int q_m[$];

  // Model: cycle index since reset release plus timestamps of the events that
  // drive every output (state entry, last key press, last increment pulse).
  int m_ncyc, m_state, m_entry, m_lastpress, m_lastinc, m_pulse0;
  bit m_armed, m_s1, m_s2, m_u1, m_u2, m_h, m_m;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  task automatic model_reset();
    m_ncyc = 0; m_state = 0; m_entry = 0; m_lastpress = -10; m_lastinc = -10;
    m_pulse0 = 0; m_armed = 0; m_s1 = 0; m_s2 = 0; m_u1 = 0; m_u2 = 0;
    m_h = 0; m_m = 0;
  endtask

  // Advance the model by one clock: events of the cycle that just ended decide
  // the outputs of the cycle that starts now.
  task automatic model_step();
    bit sp, upp, in_set, tmo, cancel, f_rise, f_rep, fire;
    int c, qref, nst;
    c      = m_ncyc + 1;
    sp     = (m_ncyc >= 2) && m_s1 && !m_s2;
    upp    = (m_ncyc >= 2) && m_u1 && !m_u2;
    in_set = (m_state != 0);
    qref   = imax(m_entry, m_lastpress + 1);
    tmo    = in_set && !sp && !upp && (m_ncyc - qref == TMO - 1);
    cancel = !in_set || sp || tmo;
    f_rise = upp && !cancel;
    f_rep  = m_armed && m_u1 && !cancel && (c - m_pulse0 >= HOLD) &&
             ((c - m_pulse0 - HOLD) % REP == 0);
    fire   = f_rise || f_rep;
    m_h    = fire && (m_state == 1);
    m_m    = fire && (m_state == 2);
    if (fire) m_lastinc = c;
    if (f_rise) begin
      m_armed = 1; m_pulse0 = c;
    end else if (!m_u1 || cancel) begin
      m_armed = 0;
    end
    nst = sp ? ((m_state + 1) % 3) : (tmo ? 0 : m_state);
    if (nst != m_state) m_entry = c;
    if (sp || upp) m_lastpress = m_ncyc;
    m_state = nst;
    m_s2 = m_s1; m_s1 = key_set;
    m_u2 = m_u1; m_u1 = key_up;
    m_ncyc = c;
  endtask

  function automatic int exp_blank();
    int ph;
    if (m_state == 0) return 0;
    ph = ((m_ncyc - imax(m_entry, m_lastinc)) / BLK) % 2;
    return (m_state == 1) ? ph * 12 : ph * 3;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge CLK_1M or posedge clr);
      if (clr) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare and event monitor
  initial begin
    forever begin
      @(negedge CLK_1M);
      tb_cyc++;
      chk("state", int'(set_state), m_state);
      chk("enable", int'(enable), (m_state == 0) ? 1 : 0);
      chk("hadd", int'(hadd), int'(m_h));
      chk("madd", int'(madd), int'(m_m));
      chk("blank", int'(blank), exp_blank());
      if (hadd) cnt_h++;
      if (madd) begin
        cnt_m++;
        q_m.push_back(tb_cyc);
      end
      if (set_state != prev_ss) begin
        prev_ss  = set_state;
        last_chg = tb_cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_1M);
    #1;
  endtask

  task automatic press_set();
    key_set = 1'b1; tick(2);
    key_set = 1'b0; tick(2);
  endtask

  int h0, m0, t1, t2, entry, len, kind;
  bit found;
  int t3_off[6];

  initial begin
    t3_off = '{0, 50, 60, 70, 80, 90};
    clr = 1'b1; key_set = 1'b1; key_up = 1'b0;
    tick(3);
    chk("rst_state", int'(set_state), 0);
    chk("rst_enable", int'(enable), 1);
    chk("rst_blank", int'(blank), 0);
    chk("rst_hadd", int'(hadd), 0);
    clr = 1'b0;
    tick(6);
    chk("held_set_no_press", int'(set_state), 0);
    key_set = 1'b0; tick(3);
    key_set = 1'b1; tick(3);
    key_set = 1'b0;
    chk("t2_state_hour", int'(set_state), 1);
    chk("t2_enable_low", int'(enable), 0);
    $display("step reset/first SET press at cycle %0d", tb_cyc);

    h0 = cnt_h; m0 = cnt_m;
    key_up = 1'b1; tick(5); key_up = 1'b0; tick(5);
    chk("t2_hadd_count", cnt_h - h0, 1);
    chk("t2_madd_quiet", cnt_m - m0, 0);
    press_set();
    chk("t2_state_min", int'(set_state), 2);
    m0 = cnt_m;
    key_up = 1'b1; tick(2); key_up = 1'b0; tick(4);
    chk("t2_madd_tap", cnt_m - m0, 1);
    $display("step single increments at cycle %0d", tb_cyc);

    q_m.delete();
    key_up = 1'b1; tick(100); key_up = 1'b0; tick(30);
    chk("t3_pulse_count", q_m.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q_m.size()) chk("t3_pulse_offset", q_m[i] - q_m[0], t3_off[i]);
    end
    $display("step auto-repeat gave %0d madd pulses", q_m.size());

    press_set();
    chk("t4_state_run", int'(set_state), 0);
    press_set();
    chk("t4_state_hour", int'(set_state), 1);
    entry = last_chg;
    found = 0; t1 = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (blank == 4'b1100) begin found = 1; t1 = tb_cyc; end
    end
    chk("t4_blink_on", int'(found), 1);
    found = 0; t2 = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (blank == 4'b0000) begin found = 1; t2 = tb_cyc; end
    end
    chk("t4_blink_off", int'(found), 1);
    chk("t4_half_period", t2 - t1, 25);
    found = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      tick(1);
      if (set_state == 2'd0) found = 1;
    end
    tick(1);
    chk("t4_timeout_seen", int'(found), 1);
    chk("t4_timeout_len", last_chg - entry, 1000);
    chk("t4_enable", int'(enable), 1);
    chk("t4_blank", int'(blank), 0);
    $display("step blink/timeout after %0d cycles", last_chg - entry);

    press_set();
    chk("t5_state_hour", int'(set_state), 1);
    h0 = cnt_h; m0 = cnt_m;
    key_set = 1'b1; key_up = 1'b1; tick(3);
    key_set = 1'b0;
    chk("t5_state_min", int'(set_state), 2);
    tick(57); key_up = 1'b0; tick(3);
    chk("t5_no_hadd", cnt_h - h0, 0);
    chk("t5_no_madd", cnt_m - m0, 0);
    $display("step simultaneous SET/UP at cycle %0d", tb_cyc);

    press_set();
    press_set();
    chk("t6_state_hour", int'(set_state), 1);
    h0 = cnt_h;
    key_up = 1'b1; tick(52);
    chk("t6_repeat_pulse", int'(hadd), 1);
    chk("t6_first_pulse", cnt_h - h0, 1);
    clr = 1'b1; #1;
    chk("t6_clr_hadd", int'(hadd), 0);
    chk("t6_clr_state", int'(set_state), 0);
    chk("t6_clr_enable", int'(enable), 1);
    @(posedge CLK_1M); #1;
    clr = 1'b0;
    h0 = cnt_h;
    tick(100); key_up = 1'b0; tick(3);
    chk("t6_no_pulse_after_clr", cnt_h - h0, 0);
    chk("t6_state_run", int'(set_state), 0);
    $display("step reset mid-hold at cycle %0d", tb_cyc);

    for (int s = 0; s < 200; s++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) begin
        len = int'($urandom_range(5, 60));
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 19) == 0) key_set = ~key_set;
          if ($urandom_range(0, 5) == 0) key_up = ~key_up;
          tick(1);
        end
      end else if (kind <= 6) begin
        key_up = 1'b0; tick(1);
        key_up = 1'b1; tick(int'($urandom_range(1, 150)));
        key_up = 1'b0; tick(1);
      end else if (kind == 7) begin
        key_set = 1'b0; key_up = 1'b0;
        tick(int'($urandom_range(900, 1100)));
      end else if (kind == 8) begin
        key_set = 1'b0; key_up = 1'b0; tick(2);
        key_set = 1'b1; key_up = 1'b1;
        tick(int'($urandom_range(1, 80)));
        key_set = 1'b0; key_up = 1'b0; tick(1);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          clr = 1'b1; tick(1); clr = 1'b0;
        end
        tick(5);
      end
    end
    key_set = 1'b0; key_up = 1'b0;
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Front-panel controller that sequences the digital clock's time-set operation. It takes the debounced SET and UP key levels and runs a RUN / SET_HOUR / SET_MIN state machine. It drives the timekeeping core's enable, madd and hadd inputs, with auto-repeat on a held UP key. It also produces a digit-blink mask for the 7-segment stage and returns to RUN on an inactivity timeout.

Parameters:
HOLD_CYC, 500000, UP held this many cycles after its press pulse before auto-repeat starts (0.5 s at 1 MHz).
REPEAT_CYC, 100000, cycles between auto-repeat pulses (0.1 s).
TIMEOUT_CYC, 10000000, cycles without a key press edge in a SET state before forced return to RUN (10 s).
BLINK_CYC, 250000, cycles per blink half-period (250 ms).

Ports:
CLK_1M  input  1  system clock, 1 MHz
clr  input  1  asynchronous active-high reset
key_set  input  1  debounced SET key level, synchronous to CLK_1M
key_up  input  1  debounced UP key level, synchronous to CLK_1M
enable  output  1  core run enable; 1 only in RUN
hadd  output  1  single-cycle hour-increment pulse to core
madd  output  1  single-cycle minute-increment pulse to core
blank  output  4  per-digit blank mask; [3:2] hour digits, [1:0] minute digits; 1 = blank
set_state  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN

Behaviour:
- Reset (async, clr=1): state=RUN, enable=1, hadd=0, madd=0, blank=4'b0000, set_state=0; all counters and edge-detect registers = 0.
- Edge detect: a press is the rising edge of the registered key level. A key held high through reset release produces no press.
- Transitions on a key_set press:
  - RUN -> SET_HOUR
  - SET_HOUR -> SET_MIN
  - SET_MIN -> RUN
- Timeout: in SET_HOUR or SET_MIN, when TIMEOUT_CYC cycles elapse with no press of either key, go to RUN. The timeout counter clears on every press and on every state entry.
- UP handling, SET states only:
  - A press generates one increment pulse in the cycle after the rising edge: hadd in SET_HOUR, madd in SET_MIN.
  - If UP is still high HOLD_CYC cycles after that pulse, another pulse is issued, then one every REPEAT_CYC cycles while UP stays high.
  - UP falling cancels repeat.
  - In RUN, key_up is ignored and no pulses are issued.
- hadd and madd are never both 1. Each pulse is exactly 1 cycle wide.
- enable = (state==RUN), registered with the state, so it deasserts in the same cycle set_state changes.
- Simultaneous key_set press and key_up press in the same cycle: the state transition wins, no increment pulse is issued, and repeat is not armed.
- A state change while UP is held cancels any pending repeat. UP must be released and pressed again to increment in the new state.
- Blink:
  - A phase bit toggles every BLINK_CYC cycles in SET states.
  - Phase resets to 0 (digits visible) on state entry and on every increment pulse, so the digit under adjustment stays lit while it changes.
  - SET_HOUR: blank = {phase, phase, 0, 0}. SET_MIN: blank = {0, 0, phase, phase}. RUN: blank = 0.
- Counter widths: each counter is sized to hold its parameter; the TIMEOUT_CYC default needs 24 bits. Counters saturate rather than wrap.
- Async reset mid-operation (including mid-pulse): outputs return to reset values immediately; no partial pulse is extended.

Decomposition:
- Shared package clock_pkg:
  - state encodings ST_RUN=2'd0, ST_SET_HOUR=2'd1, ST_SET_MIN=2'd2;
  - default cycle constants for 1 MHz.
- One sub-module, key_repeat: edge detect plus hold/repeat pulse generator, parameterised by HOLD_CYC and REPEAT_CYC, with a cancel input. It is instantiated once for key_up. The top level contains the FSM, the timeout counter, the blink logic and pulse routing.

Test Plan (HOLD_CYC=50, REPEAT_CYC=10, TIMEOUT_CYC=1000, BLINK_CYC=25):
1. Assert clr, release with key_set held high -> set_state=0, enable=1, blank=0; no transition until key_set falls and rises again.
2. Press SET once, press UP for 5 cycles -> set_state=1, enable=0, exactly one hadd pulse, madd stays 0. Press SET again, tap UP -> one madd pulse.
3. In SET_MIN, hold UP for 100 cycles -> madd pulses at press+1, then +50, +60, +70, +80, +90 relative to the first pulse (6 pulses total); none after release.
4. In SET_HOUR with no keys -> blank toggles 4'b0000 / 4'b1100 every 25 cycles. After 1000 idle cycles -> set_state=0, enable=1, blank=0.
5. In SET_HOUR, key_set and key_up rise in the same cycle -> set_state=2, no hadd or madd pulse. With UP still held for 60 cycles -> no pulses.
6. Hold UP in SET_HOUR so a repeat is pending, then assert clr for 1 cycle mid-hold -> hadd=0 immediately, state RUN, no further pulses after clr deasserts.
